// File: rtl/apogee_strobe_gen_if.sv
// rtl/apogee_strobe_gen_if.sv - turbo/stall controls and strobe outputs of the Apogee strobe generator
interface apogee_strobe_gen_if;
  logic [1:0] turbo;
  logic       stall;
  logic       ce_f1;
  logic       ce_f2;
  logic       ce_periph;
  logic       ce_pix;
  logic       ce_pix2x;
  logic       ce_ps2;
  logic [1:0] turbo_cur;

  // Consumer side: drives turbo/stall, observes strobes
  modport master (
    output turbo, stall,
    input  ce_f1, ce_f2, ce_periph, ce_pix, ce_pix2x, ce_ps2, turbo_cur
  );

  // Generator side
  modport slave (
    input  turbo, stall,
    output ce_f1, ce_f2, ce_periph, ce_pix, ce_pix2x, ce_ps2, turbo_cur
  );
endinterface

// File: rtl/apogee_strobe_gen.sv
// rtl/apogee_strobe_gen.sv - clock-enable generator for CPU phases, PIT/DMA, pixel and PS/2 strobes
module apogee_strobe_gen #(
  parameter int CPU_DIV      = 28,
  parameter int F2_DLY       = 2,
  parameter int MAX_TURBO    = 2,
  parameter int PERIPH_DIV   = 28,
  parameter int PERIPH_PHASE = 4,
  parameter int PIX_DIV      = 6,
  parameter int PS2_DIV      = 3571
) (
  input  logic                 clk,
  input  logic                 reset_n,
  apogee_strobe_gen_if.slave   bus
);

  localparam int CW       = $clog2(CPU_DIV);
  localparam int PW       = $clog2(PERIPH_DIV);
  localparam int XW       = $clog2(PIX_DIV);
  localparam int SW       = $clog2(PS2_DIV);
  localparam int NSUB_MAX = 1 << MAX_TURBO;

  logic [CW-1:0] cpu_cnt_q, cpu_cnt_d;
  logic [PW-1:0] per_cnt_q, per_cnt_d;
  logic [XW-1:0] pix_cnt_q, pix_cnt_d;
  logic [SW-1:0] ps2_cnt_q, ps2_cnt_d;
  logic [1:0]    turbo_cur_q, turbo_cur_d;
  logic          ce_f1_q, ce_f1_d;
  logic          ce_f2_q, ce_f2_d;
  logic          ce_periph_q, ce_periph_d;
  logic          ce_pix_q, ce_pix_d;
  logic          ce_pix2x_q, ce_pix2x_d;
  logic          ce_ps2_q, ce_ps2_d;

  logic [1:0]    turbo_clamp;
  logic          f1_hit;
  logic          f2_hit;
  int            sub_len;
  int            sub_cnt;

  // Clamp the requested turbo exponent to the supported maximum
  always_comb begin
    turbo_clamp = bus.turbo;
    if (int'(bus.turbo) > MAX_TURBO) turbo_clamp = 2'(MAX_TURBO);
  end

  // Sub-period boundary detection: compare cpu_cnt against each multiple of SUB
  // (offset by F2_DLY for phase 2) instead of dividing
  always_comb begin
    f1_hit  = 1'b0;
    f2_hit  = 1'b0;
    sub_len = CPU_DIV >> turbo_cur_q;
    sub_cnt = 1 << turbo_cur_q;
    for (int m = 0; m < NSUB_MAX; m++) begin
      if (m < sub_cnt) begin
        if (int'(cpu_cnt_q) == m * sub_len)          f1_hit = 1'b1;
        if (int'(cpu_cnt_q) == m * sub_len + F2_DLY) f2_hit = 1'b1;
      end
    end
  end

  // Next-state for counters, turbo latch and registered strobes
  always_comb begin
    cpu_cnt_d   = cpu_cnt_q;
    turbo_cur_d = turbo_cur_q;
    if (!bus.stall) begin
      if (cpu_cnt_q == CW'(CPU_DIV - 1)) begin
        cpu_cnt_d   = '0;
        turbo_cur_d = turbo_clamp;
      end else begin
        cpu_cnt_d = cpu_cnt_q + CW'(1);
      end
    end

    per_cnt_d = (per_cnt_q == PW'(PERIPH_DIV - 1)) ? '0 : per_cnt_q + PW'(1);
    pix_cnt_d = (pix_cnt_q == XW'(PIX_DIV - 1))    ? '0 : pix_cnt_q + XW'(1);
    ps2_cnt_d = (ps2_cnt_q == SW'(PS2_DIV - 1))    ? '0 : ps2_cnt_q + SW'(1);

    ce_f1_d     = !bus.stall && f1_hit;
    ce_f2_d     = !bus.stall && f2_hit;
    ce_periph_d = (per_cnt_q == PW'(PERIPH_PHASE));
    ce_pix_d    = (pix_cnt_q == '0);
    ce_pix2x_d  = (pix_cnt_q == '0) || (pix_cnt_q == XW'(PIX_DIV / 2));
    ce_ps2_d    = (ps2_cnt_q == '0);
  end

  // State register; reset abandons any period in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_cnt_q   <= '0;
      per_cnt_q   <= '0;
      pix_cnt_q   <= '0;
      ps2_cnt_q   <= '0;
      turbo_cur_q <= '0;
      ce_f1_q     <= 1'b0;
      ce_f2_q     <= 1'b0;
      ce_periph_q <= 1'b0;
      ce_pix_q    <= 1'b0;
      ce_pix2x_q  <= 1'b0;
      ce_ps2_q    <= 1'b0;
    end else begin
      cpu_cnt_q   <= cpu_cnt_d;
      per_cnt_q   <= per_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      ps2_cnt_q   <= ps2_cnt_d;
      turbo_cur_q <= turbo_cur_d;
      ce_f1_q     <= ce_f1_d;
      ce_f2_q     <= ce_f2_d;
      ce_periph_q <= ce_periph_d;
      ce_pix_q    <= ce_pix_d;
      ce_pix2x_q  <= ce_pix2x_d;
      ce_ps2_q    <= ce_ps2_d;
    end
  end

  assign bus.ce_f1     = ce_f1_q;
  assign bus.ce_f2     = ce_f2_q;
  assign bus.ce_periph = ce_periph_q;
  assign bus.ce_pix    = ce_pix_q;
  assign bus.ce_pix2x  = ce_pix2x_q;
  assign bus.ce_ps2    = ce_ps2_q;
  assign bus.turbo_cur = turbo_cur_q;

endmodule
